// File: rtl/i2c_reg_target.sv
// I2C target exposing an 8-bit register bank at a fixed 7-bit address.
// Define I2C_TARGET_TIMEOUT_EN to abort a transfer when SCL is held low.
module i2c_reg_target #(
  parameter logic [6:0] ADDR           = 7'h42,
  parameter int         NUM_REGS       = 16,
  parameter int         TIMEOUT_CYCLES = 65535,
  localparam int        IW             = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [IW-1:0] host_addr,
  output logic [7:0]    host_data,
  output logic          wr_stb,
  output logic [IW-1:0] wr_idx,
  output logic [7:0]    wr_data,
  output logic          busy
);

  if (NUM_REGS < 2 || NUM_REGS > 256 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_reg_target: bad parameter");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK,
    S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK,
    S_RDATA, S_RDATA_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          stb_q, stb_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    wdat_q, wdat_d;
  logic          we;
  logic [7:0]    regs_q [NUM_REGS];

  // [0] first sync stage, [1] synchronised level, [2] history
  logic [2:0] scl_q, sda_q;
  logic       scl_s, scl_h, sda_s, sda_h;
  logic       rise, fall, start, stop, tmo;
  logic [7:0] rx, cur;

  assign scl_s = scl_q[1];
  assign scl_h = scl_q[2];
  assign sda_s = sda_q[1];
  assign sda_h = sda_q[2];
  assign rise  = scl_s & ~scl_h;
  assign fall  = ~scl_s & scl_h;
  assign start = scl_s & scl_h & sda_h & ~sda_s;
  assign stop  = scl_s & scl_h & ~sda_h & sda_s;
  assign rx    = {sh_q[6:0], sda_s};
  assign cur   = regs_q[ptr_q];

`ifdef I2C_TARGET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tcnt_q <= '0;
    end else if (!busy_q || scl_s) begin
      tcnt_q <= '0;
    end else if (!tmo) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  assign tmo = (tcnt_q == TW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    we      = 1'b0;
    if (start) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop || tmo) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR, S_PTR: begin
          if (rise) begin
            sh_d  = rx;
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            if (state_q == S_PTR) begin
              ptr_d   = sh_q[IW-1:0];
              state_d = S_PTR_ACK;
              oe_d    = 1'b1;
            end else if (sh_q[7:1] == ADDR) begin
              state_d = S_ADDR_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        S_ADDR_ACK: begin
          if (fall) begin
            cnt_d = '0;
            if (sh_q[0]) begin
              state_d = S_RDATA;
              sh_d    = cur;
              oe_d    = ~cur[7];
            end else begin
              state_d = S_PTR;
              oe_d    = 1'b0;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (fall) begin
            state_d = S_WDATA;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        S_WDATA: begin
          if (rise) begin
            sh_d  = rx;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              we     = 1'b1;
              stb_d  = 1'b1;
              idx_d  = ptr_q;
              wdat_d = rx;
              ptr_d  = ptr_q + IW'(1);
            end
          end else if (fall && cnt_q == 4'd8) begin
            state_d = S_WDATA_ACK;
            oe_d    = 1'b1;
          end
        end
        S_RDATA: begin
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall) begin
            if (cnt_q == 4'd8) begin
              state_d = S_RDATA_ACK;
              oe_d    = 1'b0;
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
              oe_d = ~sh_q[6];
            end
          end
        end
        S_RDATA_ACK: begin
          // Entered on a fall, so the first edge seen here is the ACK rise
          if (rise) begin
            if (sda_s) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + IW'(1);
            end
          end else if (fall) begin
            state_d = S_RDATA;
            sh_d    = cur;
            oe_d    = ~cur[7];
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      scl_q   <= '1;
      sda_q   <= '1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
    end else begin
      scl_q   <= {scl_q[1:0], scl_i};
      sda_q   <= {sda_q[1:0], sda_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[ptr_q] <= rx;
    end
  end

  assign sda_oe    = oe_q;
  assign busy      = busy_q;
  assign wr_stb    = stb_q;
  assign wr_idx    = idx_q;
  assign wr_data   = wdat_q;
  assign host_data = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bus-level master tasks, register-bank model,
// directed scenarios plus randomised write/read transactions.
module tb_i2c_reg_target;

  localparam int N = 16;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_addr = '0;
  logic       sda_oe, wr_stb, busy;
  logic [7:0] host_data, wr_data;
  logic [3:0] wr_idx;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_reg_target #(
    .ADDR(7'h42),
    .NUM_REGS(N),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .scl_i(scl_m),
    .sda_i(sda_bus),
    .sda_oe(sda_oe),
    .host_addr(host_addr),
    .host_data(host_data),
    .wr_stb(wr_stb),
    .wr_idx(wr_idx),
    .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [11:0] obs_q[$];
  int unsigned oe_cnt = 0;

  always @(negedge clk) begin
    if (wr_stb) obs_q.push_back({wr_idx, wr_data});
    if (sda_oe) oe_cnt++;
  end

  logic [7:0]  mregs [N];
  int          mptr;
  logic [11:0] exp_q[$];
  int          obs_rd = 0;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bstop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic wbit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      d[i] = sda_bus; tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = ~ack; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1;
  endtask

  task automatic chk_stb(input string tag);
    chk({tag, "_nstb"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (obs_rd < obs_q.size()) begin
        chk({tag, "_stb"}, 32'(obs_q[obs_rd]), 32'(exp_q[0]));
        obs_rd++;
      end
      void'(exp_q.pop_front());
    end
    obs_rd = obs_q.size();
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < N; i++) begin
      host_addr = 4'(i);
      #1;
      chk({tag, "_reg"}, 32'(host_data), 32'(mregs[i]));
    end
  endtask

  task automatic wr_txn(input string tag, input logic [7:0] p,
                        input logic [7:0] d[$]);
    logic a;
    bstart();
    wbyte(8'h84, a); chk({tag, "_aack"}, 32'(a), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    wbyte(p, a);     chk({tag, "_pack"}, 32'(a), 1);
    mptr = int'(p) % N;
    foreach (d[k]) begin
      wbyte(d[k], a); chk({tag, "_dack"}, 32'(a), 1);
      mregs[mptr] = d[k];
      exp_q.push_back({4'(mptr), d[k]});
      mptr = (mptr + 1) % N;
    end
    bstop();
    chk({tag, "_idle"}, 32'(busy), 0);
    chk_stb(tag);
  endtask

  task automatic rd_txn(input string tag, input logic [7:0] p,
                        input int n);
    logic a;
    logic [7:0] d;
    bstart();
    wbyte(8'h84, a); chk({tag, "_aack"}, 32'(a), 1);
    wbyte(p, a);     chk({tag, "_pack"}, 32'(a), 1);
    mptr = int'(p) % N;
    bstart();
    wbyte(8'h85, a); chk({tag, "_rack"}, 32'(a), 1);
    for (int k = 0; k < n; k++) begin
      rbyte(k != n - 1, d);
      chk({tag, "_rdat"}, 32'(d), 32'(mregs[mptr]));
      if (k != n - 1) mptr = (mptr + 1) % N;
    end
    tick(2);
    chk({tag, "_rel"}, 32'(sda_oe), 0);
    bstop();
    chk({tag, "_idle"}, 32'(busy), 0);
    chk_stb(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dq[$];
    logic a;
    int unsigned oe0;

    foreach (mregs[i]) mregs[i] = 8'h00;
    mptr = 0;

    tick(3);
    chk("rst_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stb", 32'(wr_stb), 0);
    #1 chk("rst_reg0", 32'(host_data), 0);
    nRst = 1'b1;
    tick(4);

    dq = '{8'hA5, 8'h5A};
    wr_txn("wr", 8'h03, dq);
    host_addr = 4'd4;
    #1 chk("wr_host4", 32'(host_data), 32'h5A);

    rd_txn("rd", 8'h03, 2);

    oe0 = oe_cnt;
    bstart();
    wbyte(8'h86, a); chk("bad_aack", 32'(a), 0);
    wbyte(8'h00, a); chk("bad_ack0", 32'(a), 0);
    wbyte(8'hFF, a); chk("bad_ack1", 32'(a), 0);
    bstop();
    chk("bad_oe", oe_cnt - oe0, 0);
    chk("bad_busy", 32'(busy), 0);
    chk_stb("bad");
    chk_regs("bad");

    dq = '{8'h11, 8'h22, 8'h33};
    wr_txn("wrap", 8'h0F, dq);
    dq = '{8'h77};
    wr_txn("ptr13", 8'h13, dq);
    chk_regs("wrap");
    rd_txn("wraprd", 8'h0F, 3);

    for (int it = 0; it < 5; it++) begin
      dq.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        dq.push_back(8'($urandom));
      wr_txn("rnd_wr", 8'($urandom), dq);
      rd_txn("rnd_rd", 8'($urandom), int'($urandom_range(1, 4)));
    end
    chk_regs("rnd");

    bstart();
    wbyte(8'h84, a); chk("to_aack", 32'(a), 1);
    tick(120);
`ifdef I2C_TARGET_TIMEOUT_EN
    chk("to_busy", 32'(busy), 0);
`else
    chk("to_busy", 32'(busy), 1);
`endif
    chk("to_oe", 32'(sda_oe), 0);
    bstop();
    chk("to_stop", 32'(busy), 0);

    bstart();
    wbyte(8'h84, a); chk("ab_aack", 32'(a), 1);
    wbyte(8'h07, a); chk("ab_pack", 32'(a), 1);
    for (int i = 0; i < 4; i++) wbit(1'b1);
    bstop();
    chk_stb("ab_part");
    chk_regs("ab_part");

    bstart();
    for (int i = 7; i >= 0; i--) wbit(i == 7 || i == 2);
    sda_m = 1'b1; tick(Q);
    chk("ab_ackoe", 32'(sda_oe), 1);
    nRst = 1'b0;
    #1 chk("ab_rstoe", 32'(sda_oe), 0);
    chk("ab_rstbusy", 32'(busy), 0);
    tick(2);
    nRst = 1'b1;
    scl_m = 1'b1;
    tick(Q);
    foreach (mregs[i]) mregs[i] = 8'h00;
    mptr = 0;
    chk_regs("ab_rst");
    chk_stb("ab_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
